// File: rtl/track_window_ctrl.sv
// Closed-loop tracking controller: validates correlator results, updates the tracked box and issues the next search window.
// Optional EMA smoothing of the box position is enabled by defining TRACK_SMOOTH_EN.
module track_window_ctrl #(
  parameter int VGA_W        = 640,
  parameter int VGA_H        = 480,
  parameter int TMPL_W       = 32,
  parameter int MARGIN       = 16,
  parameter int MISS_LIMIT   = 4,
  parameter int SCORE_THRESH = 2000,
  parameter int SMOOTH_SHIFT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tracking_mode,
  input  logic [9:0] init_x,
  input  logic [9:0] init_y,
  input  logic       max_ready,
  input  logic [9:0] max_x,
  input  logic [9:0] max_y,
  input  logic [15:0] max_score,
  output logic [9:0] c_x,
  output logic [9:0] c_y,
  output logic [9:0] win_left,
  output logic [9:0] win_right,
  output logic [9:0] win_top,
  output logic [9:0] win_bottom,
  output logic       search_start,
  output logic       locked,
  output logic       lost
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;

  localparam logic signed [11:0] XMAX_S   = 12'(VGA_W - TMPL_W);
  localparam logic signed [11:0] YMAX_S   = 12'(VGA_H - TMPL_W);
  localparam logic signed [11:0] RMAX_S   = 12'(VGA_W - 1);
  localparam logic signed [11:0] BMAX_S   = 12'(VGA_H - 1);
  localparam logic signed [11:0] MARGIN_S = 12'(MARGIN);
  localparam logic signed [11:0] SPAN_S   = 12'(TMPL_W - 1 + MARGIN);
  localparam logic [9:0]         FULL_R   = 10'(VGA_W - 1);
  localparam logic [9:0]         FULL_B   = 10'(VGA_H - 1);
  localparam logic [15:0]        THRESH   = 16'(SCORE_THRESH);
  localparam logic [7:0]         MISS_LIM = 8'(MISS_LIMIT);

  state_t r_state, w_next;

  logic [9:0]  r_cx, r_cy, r_wl, r_wr, r_wt, r_wb;
  logic        r_ss, r_locked, r_lost;
  logic [7:0]  r_miss, w_miss_inc;
  logic [9:0]  r_mx, r_my;
  logic [15:0] r_score;

  function automatic logic [9:0] clamp(input logic signed [11:0] v, input logic signed [11:0] hi);
    logic signed [11:0] r;
    r = v;
    if (r < 12'sd0) r = 12'sd0;
    else if (r > hi) r = hi;
    return r[9:0];
  endfunction

  function automatic logic signed [11:0] filt(input logic [9:0] c, input logic [9:0] m);
`ifdef TRACK_SMOOTH_EN
    logic signed [10:0] d, sh;
    d  = $signed({1'b0, m}) - $signed({1'b0, c});
    sh = d >>> SMOOTH_SHIFT;
    // Small errors would shift to zero and stall; force a unit step toward the target.
    if (d != 11'sd0 && sh == 11'sd0) sh = d[10] ? -11'sd1 : 11'sd1;
    return $signed({2'b00, c}) + 12'(sh);
`else
    logic [9:0] unused_c;
    unused_c = c;
    return $signed({2'b00, m}) + 12'(unused_c & 10'd0);
`endif
  endfunction

  assign w_miss_inc = (r_miss >= MISS_LIM) ? MISS_LIM : r_miss + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!tracking_mode) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = ISSUE;
        ISSUE:   w_next = WAIT;
        WAIT:    if (max_ready) w_next = UPDATE;
        UPDATE:  w_next = ISSUE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Result capture: data path only, no reset needed
  always_ff @(posedge clk) begin
    if (r_state == WAIT && max_ready) begin
      r_mx    <= max_x;
      r_my    <= max_y;
      r_score <= max_score;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_wl     <= '0;
      r_wr     <= FULL_R;
      r_wt     <= '0;
      r_wb     <= FULL_B;
      r_ss     <= 1'b0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
      r_miss   <= '0;
    end else begin
      r_ss <= 1'b0;
      if (!tracking_mode || r_state == IDLE) begin
        r_wl     <= '0;
        r_wr     <= FULL_R;
        r_wt     <= '0;
        r_wb     <= FULL_B;
        r_locked <= 1'b0;
        r_lost   <= 1'b0;
        if (tracking_mode) begin
          r_cx   <= clamp($signed({2'b00, init_x}), XMAX_S);
          r_cy   <= clamp($signed({2'b00, init_y}), YMAX_S);
          r_miss <= '0;
        end
      end else begin
        case (r_state)
          ISSUE: begin
            r_ss <= 1'b1;
            if (r_lost) begin
              r_wl <= '0;
              r_wr <= FULL_R;
              r_wt <= '0;
              r_wb <= FULL_B;
            end else begin
              r_wl <= clamp($signed({2'b00, r_cx}) - MARGIN_S, RMAX_S);
              r_wr <= clamp($signed({2'b00, r_cx}) + SPAN_S, RMAX_S);
              r_wt <= clamp($signed({2'b00, r_cy}) - MARGIN_S, BMAX_S);
              r_wb <= clamp($signed({2'b00, r_cy}) + SPAN_S, BMAX_S);
            end
          end
          UPDATE: begin
            if (r_score <= THRESH) begin
              r_miss   <= '0;
              r_locked <= 1'b1;
              r_lost   <= 1'b0;
              // Re-acquisition after loss jumps straight to the match.
              if (r_lost) begin
                r_cx <= clamp($signed({2'b00, r_mx}), XMAX_S);
                r_cy <= clamp($signed({2'b00, r_my}), YMAX_S);
              end else begin
                r_cx <= clamp(filt(r_cx, r_mx), XMAX_S);
                r_cy <= clamp(filt(r_cy, r_my), YMAX_S);
              end
            end else begin
              r_locked <= 1'b0;
              r_miss   <= w_miss_inc;
              if (w_miss_inc == MISS_LIM) r_lost <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign c_x          = r_cx;
  assign c_y          = r_cy;
  assign win_left     = r_wl;
  assign win_right    = r_wr;
  assign win_top      = r_wt;
  assign win_bottom   = r_wb;
  assign search_start = r_ss;
  assign locked       = r_locked;
  assign lost         = r_lost;

endmodule

// File: tb/tb_track_window_ctrl.sv
// Directed self-checking bench for track_window_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_track_window_ctrl;

  logic        clk = 1'b0;
  logic        reset, tracking_mode, max_ready;
  logic [9:0]  init_x, init_y, max_x, max_y;
  logic [15:0] max_score;
  logic [9:0]  c_x, c_y, win_left, win_right, win_top, win_bottom;
  logic        search_start, locked, lost;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  track_window_ctrl dut (
    .clk(clk), .reset(reset), .tracking_mode(tracking_mode),
    .init_x(init_x), .init_y(init_y), .max_ready(max_ready),
    .max_x(max_x), .max_y(max_y), .max_score(max_score),
    .c_x(c_x), .c_y(c_y), .win_left(win_left), .win_right(win_right),
    .win_top(win_top), .win_bottom(win_bottom),
    .search_start(search_start), .locked(locked), .lost(lost)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_win(input string tag, input int l, input int r, input int t, input int b);
    chk({tag, ".left"},   32'(win_left),   32'(l));
    chk({tag, ".right"},  32'(win_right),  32'(r));
    chk({tag, ".top"},    32'(win_top),    32'(t));
    chk({tag, ".bottom"}, 32'(win_bottom), 32'(b));
  endtask

  task automatic chk_c(input string tag, input int x, input int y);
    chk({tag, ".cx"}, 32'(c_x), 32'(x));
    chk({tag, ".cy"}, 32'(c_y), 32'(y));
  endtask

  task automatic result(input int x, input int y, input int score);
    max_x = 10'(x); max_y = 10'(y); max_score = 16'(score); max_ready = 1'b1;
    tick(1);
    max_ready = 1'b0;
  endtask

  initial begin
    int ex, ey;
    reset = 1'b1; tracking_mode = 1'b0; max_ready = 1'b0;
    init_x = '0; init_y = '0; max_x = '0; max_y = '0; max_score = '0;
    tick(2);
    chk_c("rst", 0, 0);
    chk_win("rst", 0, 639, 0, 479);
    chk("rst.ss", 32'(search_start), 0);
    chk("rst.locked", 32'(locked), 0);
    chk("rst.lost", 32'(lost), 0);
    reset = 1'b0;
    tick(1);

    // Start tracking at (100,200): cycle 0 here
    init_x = 10'd100; init_y = 10'd200; tracking_mode = 1'b1;
    tick(1);
    chk("start.ss_c1", 32'(search_start), 0);
    tick(1);
    chk("start.ss_c2", 32'(search_start), 1);
    chk_win("start", 84, 147, 184, 247);
    chk("start.locked", 32'(locked), 0);
    chk("start.lost", 32'(lost), 0);
    tick(1);
    chk("start.ss_c3", 32'(search_start), 0);

    // Accepted result (110,190) score 500
    result(110, 190, 500);
    chk("acc.ss_n1", 32'(search_start), 0);
    tick(1);
`ifdef TRACK_SMOOTH_EN
    ex = 105; ey = 195;
`else
    ex = 110; ey = 190;
`endif
    chk_c("acc", ex, ey);
    chk("acc.locked", 32'(locked), 1);
    chk("acc.ss_n2", 32'(search_start), 0);
    tick(1);
    chk("acc.ss_n3", 32'(search_start), 1);
    chk_win("acc", ex - 16, ex + 47, ey - 16, ey + 47);

    // Drop to idle, then restart at (100,200)
    tracking_mode = 1'b0;
    tick(1);
    chk("idle.locked", 32'(locked), 0);
    chk_win("idle", 0, 639, 0, 479);
    tracking_mode = 1'b1;
    tick(2);
    chk("restart.ss", 32'(search_start), 1);

    // Result in the first WAIT cycle; unit-step rule
    result(101, 199, 0);
    tick(1);
    chk_c("step", 101, 199);
    chk("step.locked", 32'(locked), 1);
    tick(1);
    chk("step.ss", 32'(search_start), 1);

    // Four consecutive rejects
    for (int i = 0; i < 4; i++) begin
      result(0, 0, 3000);
      tick(1);
      chk("miss.locked", 32'(locked), 0);
      chk("miss.lost", 32'(lost), (i == 3) ? 1 : 0);
      chk_c("miss", 101, 199);
      tick(1);
      chk("miss.ss", 32'(search_start), 1);
    end
    chk_win("lostwin", 0, 639, 0, 479);

    // Re-acquire at (300,100)
    result(300, 100, 100);
    tick(1);
    chk_c("reacq", 300, 100);
    chk("reacq.lost", 32'(lost), 0);
    chk("reacq.locked", 32'(locked), 1);
    tick(1);
    chk_win("reacq", 284, 347, 84, 147);

    // Clamp of seed (5,470)
    tracking_mode = 1'b0;
    tick(1);
    init_x = 10'd5; init_y = 10'd470; tracking_mode = 1'b1;
    tick(1);
    chk_c("clamp", 5, 448);
    tick(1);
    chk_win("clamp", 0, 52, 432, 479);

    // tracking_mode falls together with max_ready
    tick(1);
    tracking_mode = 1'b0;
    result(200, 200, 0);
    chk_c("abort", 5, 448);
    chk("abort.locked", 32'(locked), 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort.ss", 32'(search_start), 0);
      tick(1);
    end

    // Synchronous reset mid-operation
    init_x = 10'd100; init_y = 10'd200; tracking_mode = 1'b1;
    tick(2);
    chk("midrst.ss_pre", 32'(search_start), 1);
    reset = 1'b1;
    tick(1);
    chk_c("midrst", 0, 0);
    chk_win("midrst", 0, 639, 0, 479);
    chk("midrst.ss", 32'(search_start), 0);
    reset = 1'b0; tracking_mode = 1'b0;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
